// File: rtl/cell_pos_writer_pkg.sv
// cell_pos_writer_pkg: default widths and FSM state encoding for the cell position writer.
// The count word written to address 0 carries the particle count in its LSBs, upper bits zero.
package cell_pos_writer_pkg;
  localparam int DEF_DATA_WIDTH = 32 * 3;
  localparam int DEF_ADDR_WIDTH = 8;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } state_t;
endpackage

// File: rtl/cell_pos_writer.sv
// cell_pos_writer: streams particle positions into one cell memory (addr 1..N), then writes the count to addr 0.
// Ports: clock/rst (async high); start/flush pulses; in_valid/in_ready/in_data/in_last position stream;
// mem_address/mem_data/mem_wren/mem_rden memory pins; done pulse; count and sticky overflow status.
module cell_pos_writer
  import cell_pos_writer_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  output logic                  mem_rden,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  overflow
);
  localparam logic [ADDR_WIDTH-1:0] CAP = ADDR_WIDTH'(PARTICLE_NUM - 1);
  state_t state, next;
  logic [ADDR_WIDTH-1:0] ptr;
  logic acc;
  assign in_ready = state == FILL;
  assign acc = in_valid & in_ready;
  assign mem_rden = 1'b0;
  always_comb begin
    next = state == IDLE ? (start ? FILL : IDLE) :
           state == FILL ? (start ? FILL : ((acc & in_last) | flush) ? COMMIT : FILL) : IDLE;
  end
  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= next;
  end
  // start outside COMMIT (re)opens a fill; a beat arriving with that start is discarded with the aborted fill
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      mem_address <= '0;
      mem_data <= '0;
      mem_wren <= 1'b0;
      done <= 1'b0;
    end else begin
      mem_wren <= 1'b0;
      done <= 1'b0;
      if (start && state != COMMIT) begin
        ptr <= ADDR_WIDTH'(1);
        count <= '0;
        overflow <= 1'b0;
      end else if (acc) begin
        if (count < CAP) begin
          mem_address <= ptr;
          mem_data <= in_data;
          mem_wren <= 1'b1;
          ptr <= ptr + 1'b1;
          count <= count + 1'b1;
        end else overflow <= 1'b1;
      end else if (state == COMMIT) begin
        mem_address <= '0;
        mem_data <= DATA_WIDTH'(count);
        mem_wren <= 1'b1;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cell_pos_writer.sv
// tb_cell_pos_writer: directed checks of the cell position writer with an 8-word cell memory.
module tb_cell_pos_writer;
  localparam int DW = 96;
  localparam int AW = 8;
  logic clock = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, flush = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, mem_wren, mem_rden, done, overflow;
  logic [AW-1:0] mem_address, count;
  logic [DW-1:0] mem_data;
  int errs = 0, checks = 0, cyc = 0, dn = 0;
  logic [AW-1:0] wa[$], ea[$];
  logic [DW-1:0] wd[$], ed[$];
  int wc[$];

  cell_pos_writer #(.DATA_WIDTH(DW), .PARTICLE_NUM(8), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .rst(rst), .start(start), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_last(in_last), .mem_address(mem_address),
    .mem_data(mem_data), .mem_wren(mem_wren), .mem_rden(mem_rden), .done(done),
    .count(count), .overflow(overflow)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;
  always @(negedge clock) begin
    if (mem_wren) begin
      wa.push_back(mem_address);
      wd.push_back(mem_data);
      wc.push_back(cyc);
    end
    if (done) dn++;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear();
    wa.delete(); wd.delete(); wc.delete(); ea.delete(); ed.delete();
    dn = 0;
  endtask

  task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ea.push_back(a);
    ed.push_back(d);
  endtask

  task automatic verify(input string tag, input int n_done);
    chk({tag, "_nwr"}, DW'(wa.size()), DW'(ea.size()));
    for (int i = 0; i < ea.size(); i++) begin
      if (i < wa.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), DW'(wa[i]), DW'(ea[i]));
        chk($sformatf("%s_data%0d", tag, i), wd[i], ed[i]);
      end
    end
    chk({tag, "_done"}, DW'(dn), DW'(n_done));
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic l);
    in_valid = 1'b1; in_data = d; in_last = l;
    step();
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, "_ready"}, DW'(in_ready), 0);
    chk({tag, "_addr"}, DW'(mem_address), 0);
    chk({tag, "_data"}, mem_data, 0);
    chk({tag, "_wren"}, DW'(mem_wren), 0);
    chk({tag, "_rden"}, DW'(mem_rden), 0);
    chk({tag, "_done"}, DW'(done), 0);
    chk({tag, "_count"}, DW'(count), 0);
    chk({tag, "_ovf"}, DW'(overflow), 0);
  endtask

  initial begin
    logic [DW-1:0] a, b, c;
    a = {32'h3f800000, 32'h40000000, 32'h40400000};
    b = {32'h40800000, 32'h40a00000, 32'h40c00000};
    c = {32'h40e00000, 32'h41000000, 32'h41100000};
    #1 idle_outputs("reset");
    step(); rst = 1'b0; step();

    clear();
    pulse_start();
    chk("basic_ready_after_start", DW'(in_ready), 1);
    beat(a, 1'b0);
    chk("basic_wr1_wren", DW'(mem_wren), 1);
    chk("basic_wr1_addr", DW'(mem_address), 1);
    beat(b, 1'b0);
    beat(c, 1'b1);
    chk("basic_commit_ready", DW'(in_ready), 0);
    chk("basic_wr3_addr", DW'(mem_address), 3);
    step();
    chk("basic_cnt_wren", DW'(mem_wren), 1);
    chk("basic_cnt_addr", DW'(mem_address), 0);
    chk("basic_cnt_data", mem_data, 3);
    chk("basic_cnt_done", DW'(done), 1);
    step();
    chk("basic_wren_low", DW'(mem_wren), 0);
    chk("basic_done_low", DW'(done), 0);
    chk("basic_count", DW'(count), 3);
    chk("basic_count_hold_ready", DW'(in_ready), 0);
    exp_wr(1, a); exp_wr(2, b); exp_wr(3, c); exp_wr(0, 3);
    verify("basic", 1);
    if (wc.size() == 4) begin
      chk("basic_gap01", DW'(wc[1] - wc[0]), 1);
      chk("basic_gap12", DW'(wc[2] - wc[1]), 1);
      chk("basic_gap23", DW'(wc[3] - wc[2]), 1);
    end

    clear();
    pulse_start();
    chk("empty_clears_count", DW'(count), 0);
    flush = 1'b1; step(); flush = 1'b0;
    chk("empty_commit_ready", DW'(in_ready), 0);
    start = 1'b1; step(); start = 1'b0;
    chk("empty_start_ignored", DW'(in_ready), 0);
    step(); step();
    chk("empty_count", DW'(count), 0);
    chk("empty_ovf", DW'(overflow), 0);
    exp_wr(0, 0);
    verify("empty", 1);

    clear();
    pulse_start();
    for (int i = 1; i <= 9; i++) begin
      chk($sformatf("ovf_ready%0d", i), DW'(in_ready), 1);
      beat(DW'(32'h100 + i), i == 9);
    end
    step(); step(); step();
    chk("ovf_flag", DW'(overflow), 1);
    chk("ovf_count", DW'(count), 7);
    for (int i = 1; i <= 7; i++) exp_wr(AW'(i), DW'(32'h100 + i));
    exp_wr(0, 7);
    verify("ovf", 1);

    clear();
    pulse_start();
    beat(a, 1'b0);
    beat(b, 1'b0);
    pulse_start();
    chk("abort_count_cleared", DW'(count), 0);
    chk("abort_ovf_cleared", DW'(overflow), 0);
    beat(c, 1'b1);
    step(); step(); step();
    chk("abort_count", DW'(count), 1);
    exp_wr(1, a); exp_wr(2, b); exp_wr(1, c); exp_wr(0, 1);
    verify("abort", 1);

    clear();
    pulse_start();
    beat(a, 1'b0);
    beat(b, 1'b0);
    #1 rst = 1'b1;
    #1 idle_outputs("midrst");
    step(); step();
    chk("midrst_nwr", DW'(wa.size()), 1);
    chk("midrst_no_done", DW'(dn), 0);
    rst = 1'b0;
    step();
    idle_outputs("post_rst");
    clear();
    pulse_start();
    beat(c, 1'b0);
    beat(b, 1'b0);
    beat(a, 1'b1);
    step(); step(); step();
    chk("rst_refill_count", DW'(count), 3);
    exp_wr(1, c); exp_wr(2, b); exp_wr(3, a); exp_wr(0, 3);
    verify("rst_refill", 1);

    clear();
    pulse_start();
    beat(b, 1'b0);
    in_data = {3{32'hdeadbeef}};
    step(); step();
    beat(c, 1'b0);
    in_data = {3{32'hbadc0ffe}}; in_last = 1'b1;
    step(); step();
    in_last = 1'b0;
    in_valid = 1'b1; in_data = a; in_last = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0; flush = 1'b0; in_data = '0;
    step(); step(); step(); step();
    chk("gap_count", DW'(count), 3);
    chk("gap_ovf", DW'(overflow), 0);
    exp_wr(1, b); exp_wr(2, c); exp_wr(3, a); exp_wr(0, 3);
    verify("gap", 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/cell_pos_writer.md
# cell_pos_writer

Write-side controller for one per-cell position memory (single-port, address 0 = particle count, addresses 1..N = {posz, posy, posx}). It accepts a valid/ready stream of particle positions for one cell, typically from the motion-update stage. Each position is written to consecutive addresses from 1 upward. After the last particle it writes the final count to address 0 and signals completion. It drives the memory's address, data, rden and wren pins directly.

## Interface
Parameters:
- DATA_WIDTH, 32*3: position word width, {posz, posy, posx}, each 32-bit float.
- PARTICLE_NUM, 220: memory depth in words; particle capacity is PARTICLE_NUM-1.
- ADDR_WIDTH, 8: memory address width; ceil(log2(PARTICLE_NUM)) ≤ ADDR_WIDTH.

Ports:
- clock  in  1  single clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse that opens a new fill of the cell.
- flush  in  1  one-cycle pulse that closes the fill without a data beat (allows empty cells).
- in_valid  in  1  position beat valid.
- in_ready  out  1  writer can accept a beat.
- in_data  in  DATA_WIDTH  position {posz, posy, posx}.
- in_last  in  1  marks the final beat of the cell.
- mem_address  out  ADDR_WIDTH  to memory address.
- mem_data  out  DATA_WIDTH  to memory data.
- mem_wren  out  1  to memory wren.
- mem_rden  out  1  to memory rden; constant 0.
- done  out  1  one-cycle pulse when the count word is written.
- count  out  ADDR_WIDTH  particles committed in the current or last fill.
- overflow  out  1  sticky per fill: at least one beat was dropped because the cell was full.

## Operation
- States: IDLE, FILL, COMMIT.
- IDLE:
  - in_ready=0.
  - start → FILL. The start cycle loads the write pointer to 1 and clears count and overflow.
- FILL:
  - in_ready=1.
  - An accepted beat (in_valid & in_ready) with count < PARTICLE_NUM-1 writes in_data to the pointer address, increments the pointer, and increments count.
  - A beat accepted when count = PARTICLE_NUM-1 is not written. It is consumed (never stalls), overflow is set, and count saturates.
  - An accepted beat with in_last, or a flush pulse → COMMIT. flush together with an in_last beat in the same cycle: the beat is written, then exactly one commit follows.
  - start in FILL aborts the fill: pointer=1, count=0, overflow=0, stay in FILL, no count write. Address 0 keeps its previous value.
- COMMIT:
  - in_ready=0.
  - Issues one write of count to address 0. count is zero-extended into the low ADDR_WIDTH bits of mem_data; the upper bits are 0.
  - Then → IDLE. start is ignored in COMMIT.
- count and overflow hold their values in IDLE until the next start.
- Reset, at any time including mid-fill: state=IDLE, in_ready=0, mem_address=0, mem_data=0, mem_wren=0, mem_rden=0, done=0, count=0, overflow=0.
  - An in-flight fill is abandoned with no count write. Position words already written stay in memory, but address 0 is not updated.

## Timing
- All memory-side outputs and done are registered.
- Beat accepted in cycle t → mem_wren=1 with its address and data in cycle t+1.
- start in cycle t → in_ready=1 in cycle t+1.
- Last beat (or flush) accepted in cycle t:
  - cycle t+1: state COMMIT, in_ready=0.
  - cycle t+2: count write on the memory pins (mem_address=0, mem_wren=1) and done=1; state IDLE.
- Sustained throughput is 1 beat/cycle with no bubbles.
- The memory write has no latency visible to this block. A reader must allow the memory's 2-cycle read latency.
- mem_wren is 0 in every cycle without a write.

## Structure
- Shared package/define file: DATA_WIDTH and ADDR_WIDTH defaults, the state encoding (IDLE=2'd0, FILL=2'd1, COMMIT=2'd2), and the count-word packing rule (count in LSBs).
- A single flat module; no sub-module. One instance per cell memory, sitting alongside that memory instance.

## Test plan
- Basic fill:
  - Stimulus: start; 3 back-to-back beats A, B, C with last on C.
  - Required: writes addr 1=A, 2=B, 3=C on consecutive cycles, then addr 0=3 two cycles after C is accepted; done pulses once; count=3.
- Empty cell:
  - Stimulus: start, then flush.
  - Required: single write addr 0=0; done pulses; count=0; overflow=0.
- Overflow, with PARTICLE_NUM=8:
  - Stimulus: start; 9 beats, last on the 9th.
  - Required: addresses 1..7 written; beats 8–9 dropped with in_ready held 1; overflow=1; addr 0=7.
- Abort:
  - Stimulus: start, 2 beats, start again, 1 beat with last.
  - Required: second fill writes addr 1; addr 0=1; no count write from the aborted fill; done pulses once.
- Reset mid-fill:
  - Stimulus: assert rst asynchronously after 2 beats.
  - Required: all outputs 0 immediately; no addr-0 write; the next start/fill behaves as in the basic-fill scenario.
- Backpressure/gaps and flush+last:
  - Stimulus: in_valid toggling with idle gaps; flush coincident with the last beat.
  - Required: only accepted beats are written, to contiguous addresses; exactly one count write.
